// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter.
// Generates BCLK, WS and SDATA from a single clock and serializes one buffered
// stereo PCM sample per frame (MSB first, zero padded to SLOT_BITS per channel).
// A single holding register is filled through a valid/ready handshake; each frame
// load takes the held sample, or re-sends the previous frame when it is empty.
// Optional build macro: I2S_TX_UNDERRUN_ZERO_EN -- when defined, an empty-hold
// frame load sends silence and clears the remembered frame instead of repeating it.
module i2s_tx #(
  parameter int WIDTH     = 16,
  parameter int SLOT_BITS = 32,
  parameter int CLK_DIV   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sample_l,
  input  logic [WIDTH-1:0] sample_r,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             i2s_bclk,
  output logic             i2s_ws,
  output logic             i2s_sdata,
  output logic             frame_start,
  output logic             underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BCW        = $clog2(FRAME_BITS);
  localparam int DCW        = $clog2(CLK_DIV) + 1;

  localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_BITS - 1);
  localparam logic [BCW-1:0] SLOT_C   = BCW'(SLOT_BITS);
  localparam logic [BCW-1:0] WS_LO    = BCW'(SLOT_BITS - 1);
  localparam logic [BCW-1:0] WS_HI    = BCW'(FRAME_BITS - 2);
  localparam logic [BCW-1:0] WIDTH_C  = BCW'(WIDTH);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);

  // Registered state
  logic [DCW-1:0]   div_cnt_r;
  logic             bclk_r;
  logic [BCW-1:0]   bit_cnt_r;
  logic             ws_r;
  logic             sdata_r;
  logic             ready_r;
  logic             frame_start_r;
  logic             underrun_r;
  logic             hold_full_r;
  logic [WIDTH-1:0] hold_l_r;
  logic [WIDTH-1:0] hold_r_r;
  logic [WIDTH-1:0] frame_l_r;
  logic [WIDTH-1:0] frame_r_r;

  // Combinational next-state values
  logic             div_wrap_s;
  logic [DCW-1:0]   div_cnt_nxt_s;
  logic             fall_tick_s;
  logic             load_s;
  logic [BCW-1:0]   bit_cnt_nxt_s;
  logic             xfer_s;
  logic             hold_full_nxt_s;
  logic [WIDTH-1:0] frame_l_nxt_s;
  logic [WIDTH-1:0] frame_r_nxt_s;
  logic [BCW-1:0]   slot_bit_s;
  logic [WIDTH-1:0] word_s;
  logic [WIDTH-1:0] mask_s;
  logic             sdata_nxt_s;
  logic             ws_nxt_s;

  assign sample_ready = ready_r;
  assign i2s_bclk     = bclk_r;
  assign i2s_ws       = ws_r;
  assign i2s_sdata    = sdata_r;
  assign frame_start  = frame_start_r;
  assign underrun     = underrun_r;

  // Bit-clock divider: wrap detection and the falling-edge tick of BCLK.
  always_comb begin
    div_wrap_s    = 1'b0;
    div_cnt_nxt_s = div_cnt_r;
    if (div_cnt_r == DIV_LAST) begin
      div_wrap_s    = 1'b1;
      div_cnt_nxt_s = '0;
    end else begin
      div_wrap_s    = 1'b0;
      div_cnt_nxt_s = div_cnt_r + DCW'(1);
    end
    fall_tick_s = div_wrap_s & bclk_r;
  end

  // Frame bit counter advance; the wrap to bit 0 on a fall tick is the frame load.
  always_comb begin
    bit_cnt_nxt_s = bit_cnt_r;
    load_s        = 1'b0;
    if (bit_cnt_r == BIT_LAST) begin
      bit_cnt_nxt_s = '0;
      load_s        = fall_tick_s;
    end else begin
      bit_cnt_nxt_s = bit_cnt_r + BCW'(1);
      load_s        = 1'b0;
    end
  end

  // Handshake: a transfer fills the hold register, a frame load empties it.
  // A transfer in the load cycle lands in the hold register after the load has
  // already seen it empty, so the new sample waits for the following frame.
  always_comb begin
    xfer_s          = sample_valid & ready_r;
    hold_full_nxt_s = xfer_s | (hold_full_r & ~load_s);
  end

  // Frame contents after this clock: held sample on load, or the underrun policy.
  always_comb begin
    frame_l_nxt_s = frame_l_r;
    frame_r_nxt_s = frame_r_r;
    if (load_s) begin
      if (hold_full_r) begin
        frame_l_nxt_s = hold_l_r;
        frame_r_nxt_s = hold_r_r;
      end else begin
`ifdef I2S_TX_UNDERRUN_ZERO_EN
        frame_l_nxt_s = '0;
        frame_r_nxt_s = '0;
`else
        frame_l_nxt_s = frame_l_r;
        frame_r_nxt_s = frame_r_r;
`endif
      end
    end else begin
      frame_l_nxt_s = frame_l_r;
      frame_r_nxt_s = frame_r_r;
    end
  end

  // Serial bit and word select for the upcoming bit position (MSB first, zero pad).
  always_comb begin
    slot_bit_s  = bit_cnt_nxt_s;
    word_s      = frame_l_nxt_s;
    mask_s      = '0;
    sdata_nxt_s = 1'b0;
    if (bit_cnt_nxt_s < SLOT_C) begin
      slot_bit_s = bit_cnt_nxt_s;
      word_s     = frame_l_nxt_s;
    end else begin
      slot_bit_s = bit_cnt_nxt_s - SLOT_C;
      word_s     = frame_r_nxt_s;
    end
    if (slot_bit_s < WIDTH_C) begin
      mask_s      = WIDTH'(1'b1) << (WIDTH_C - BCW'(1) - slot_bit_s);
      sdata_nxt_s = |(word_s & mask_s);
    end else begin
      mask_s      = '0;
      sdata_nxt_s = 1'b0;
    end
    // WS rises on the last bit of the left slot so it leads the right MSB by one BCLK.
    if ((bit_cnt_nxt_s >= WS_LO) && (bit_cnt_nxt_s <= WS_HI)) begin
      ws_nxt_s = 1'b1;
    end else begin
      ws_nxt_s = 1'b0;
    end
  end

  // Divider counter and BCLK toggle at every divider wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r <= '0;
      bclk_r    <= 1'b0;
    end else begin
      div_cnt_r <= div_cnt_nxt_s;
      if (div_wrap_s) begin
        bclk_r <= ~bclk_r;
      end
    end
  end

  // Bit counter, WS and SDATA change only on the BCLK falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_r <= BIT_LAST;
      ws_r      <= 1'b0;
      sdata_r   <= 1'b0;
    end else if (fall_tick_s) begin
      bit_cnt_r <= bit_cnt_nxt_s;
      ws_r      <= ws_nxt_s;
      sdata_r   <= sdata_nxt_s;
    end
  end

  // Shift frame holds the stereo pair currently on the wire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_l_r <= '0;
      frame_r_r <= '0;
    end else begin
      frame_l_r <= frame_l_nxt_s;
      frame_r_r <= frame_r_nxt_s;
    end
  end

  // Holding register and registered ready flag (ready mirrors hold empty).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full_r <= 1'b0;
      ready_r     <= 1'b1;
      hold_l_r    <= '0;
      hold_r_r    <= '0;
    end else begin
      hold_full_r <= hold_full_nxt_s;
      ready_r     <= ~hold_full_nxt_s;
      if (xfer_s) begin
        hold_l_r <= sample_l;
        hold_r_r <= sample_r;
      end
    end
  end

  // One-clock status pulses raised by a frame load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      frame_start_r <= load_s;
      underrun_r    <= load_s & ~hold_full_r;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx (WIDTH=16, SLOT_BITS=32, CLK_DIV=4).
// A monitor decodes each frame on BCLK rising edges; a vector table drives
// pushes frame by frame, followed by hand-written multi-cycle corner cases.
module tb_i2s_tx;

`ifdef I2S_TX_UNDERRUN_ZERO_EN
  localparam bit UZ = 1'b1;
`else
  localparam bit UZ = 1'b0;
`endif
  localparam int NF = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample_l = 16'h0000;
  logic [15:0] sample_r = 16'h0000;
  logic        sample_valid = 1'b0;
  logic        sample_ready, i2s_bclk, i2s_ws, i2s_sdata, frame_start, underrun;

  always #5 clk = ~clk;

  i2s_tx #(.WIDTH(16), .SLOT_BITS(32), .CLK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .i2s_bclk(i2s_bclk),
    .i2s_ws(i2s_ws), .i2s_sdata(i2s_sdata), .frame_start(frame_start), .underrun(underrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor results per frame index and expectations per frame index
  int          fs_cnt = 0;
  logic [15:0] f_l [NF];
  logic [15:0] f_r [NF];
  bit          f_und [NF];
  bit          f_done [NF];
  bit          f_pad [NF];
  bit          f_ws [NF];
  bit          e_v [NF];
  logic [15:0] e_l [NF];
  logic [15:0] e_r [NF];
  bit          e_u [NF];

  typedef struct {
    bit          push;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] el;
    logic [15:0] er;
    bit          eu;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_exp(input int idx, input logic [15:0] l, input logic [15:0] r, input bit u);
    if (idx >= 0 && idx < NF) begin
      e_v[idx] = 1'b1; e_l[idx] = l; e_r[idx] = r; e_u[idx] = u;
    end
  endtask

  // Returns at negedge+1 of the clock where the next frame_start is high.
  task automatic wait_fs(output int idx);
    int start;
    start = fs_cnt;
    idx = -1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk); #1;
      if (fs_cnt != start) begin
        idx = fs_cnt - 1;
        break;
      end
    end
    if (idx < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_fs: no frame_start within 1200 clk");
    end
  endtask

  // Present a sample until accepted; reports the clocks waited and frame_start at accept.
  task automatic push(input logic [15:0] l, input logic [15:0] r, output int waited, output logic fs_seen);
    sample_l = l; sample_r = r; sample_valid = 1'b1; waited = 0;
    while (sample_ready !== 1'b1 && waited < 1500) begin
      @(negedge clk); #1;
      waited++;
    end
    fs_seen = frame_start;
    if (sample_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: ready never rose for %h/%h", l, r);
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bclk"},  32'(i2s_bclk),     32'd0);
    chk({tag, "_ws"},    32'(i2s_ws),       32'd0);
    chk({tag, "_sdata"}, 32'(i2s_sdata),    32'd0);
    chk({tag, "_ready"}, 32'(sample_ready), 32'd1);
    chk({tag, "_fs"},    32'(frame_start),  32'd0);
    chk({tag, "_und"},   32'(underrun),     32'd0);
  endtask

  // Frame monitor: 64 BCLK rising-edge samples after each frame_start.
  initial begin : monitor
    logic [63:0] bits;
    logic [63:0] wsb;
    int          rises;
    logic        prev;
    int          idx;
    bit          ok;
    forever begin
      @(negedge clk);
      if (reset_n && frame_start && fs_cnt < NF) begin
        idx = fs_cnt;
        fs_cnt++;
        f_und[idx] = underrun;
        f_done[idx] = 1'b0;
        bits = '0; wsb = '0; rises = 0; prev = i2s_bclk;
        for (int c = 0; c < 600 && rises < 64; c++) begin
          @(negedge clk);
          if (!reset_n) break;
          if (i2s_bclk && !prev) begin
            bits[rises] = i2s_sdata;
            wsb[rises] = i2s_ws;
            rises++;
          end
          prev = i2s_bclk;
        end
        for (int i = 0; i < 16; i++) begin
          f_l[idx][15-i] = bits[i];
          f_r[idx][15-i] = bits[32+i];
        end
        ok = 1'b1;
        for (int i = 16; i < 32; i++) if (bits[i] || bits[i+32]) ok = 1'b0;
        f_pad[idx] = ok;
        ok = 1'b1;
        for (int i = 0; i < 64; i++) if (wsb[i] != ((i >= 31) && (i <= 62))) ok = 1'b0;
        f_ws[idx] = ok;
        f_done[idx] = (rises == 64);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   idx, base, r0, cnt, w;
    logic fsa;

    tbl[0] = '{1'b1, 16'hA5F0, 16'h0F0F, 16'hA5F0, 16'h0F0F, 1'b0};
    tbl[1] = '{1'b0, 16'h0000, 16'h0000, UZ ? 16'h0000 : 16'hA5F0, UZ ? 16'h0000 : 16'h0F0F, 1'b1};
    tbl[2] = '{1'b1, 16'h1234, 16'h8001, 16'h1234, 16'h8001, 1'b0};
    tbl[3] = '{1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 1'b0};
    tbl[4] = '{1'b1, 16'h0001, 16'h7FFE, 16'h0001, 16'h7FFE, 1'b0};
    tbl[5] = '{1'b0, 16'h0000, 16'h0000, UZ ? 16'h0000 : 16'h0001, UZ ? 16'h0000 : 16'h7FFE, 1'b1};

    // Reset for 3 clocks, release on a falling edge
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("in_reset");
    @(negedge clk);
    reset_n = 1'b1;

    // First fall tick is the 8th rising edge after release (clk 7 counting from 0)
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      cnt++;
      if (frame_start) break;
    end
    chk("first_fs_delay", 32'(cnt), 32'd8);
    chk("first_fs_und", 32'(underrun), 32'd1);
    chk("first_fs_sdata", 32'(i2s_sdata), 32'd0);
    chk("first_fs_ws", 32'(i2s_ws), 32'd0);
    set_exp(fs_cnt - 1, 16'h0000, 16'h0000, 1'b1);

    // Table: each row decides the push for the frame after the current one
    for (int k = 0; k < 6; k++) begin
      if (tbl[k].push) begin
        push(tbl[k].l, tbl[k].r, w, fsa);
        chk($sformatf("tbl%0d_accept_wait", k), 32'(w), 32'd0);
      end
      wait_fs(idx);
      set_exp(idx, tbl[k].el, tbl[k].er, tbl[k].eu);
    end
    base = idx;

    // Back-to-back samples with valid held: ready gates the second and third
    push(16'h1111, 16'h2222, w, fsa);
    chk("stream_ready_low", 32'(sample_ready), 32'd0);
    push(16'h3333, 16'h4444, w, fsa);
    chk("stream2_waited", 32'(w > 0), 32'd1);
    chk("stream2_ready_with_fs", 32'(fsa), 32'd1);
    push(16'h5555, 16'h6666, w, fsa);
    chk("stream3_waited", 32'(w > 0), 32'd1);
    chk("stream3_ready_with_fs", 32'(fsa), 32'd1);
    set_exp(base + 1, 16'h1111, 16'h2222, 1'b0);
    set_exp(base + 2, 16'h3333, 16'h4444, 1'b0);
    set_exp(base + 3, 16'h5555, 16'h6666, 1'b0);
    wait_fs(idx);
    chk("stream_frame_index", 32'(idx), 32'(base + 3));

    // Reset at bit_cnt 52 (right slot bit 20) with a sample held
    wait_fs(idx);
    chk("pre_rst_underrun", 32'(underrun), 32'd1);
    push(16'hDEAD, 16'hBEEF, w, fsa);
    repeat (420) @(negedge clk);
    #1;
    chk("pre_rst_bclk", 32'(i2s_bclk), 32'd1);
    chk("pre_rst_ws", 32'(i2s_ws), 32'd1);
    chk("pre_rst_ready", 32'(sample_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    wait_fs(r0);
    chk("post_rst_underrun", 32'(underrun), 32'd1);
    set_exp(r0, 16'h0000, 16'h0000, 1'b1);

    // Valid presented in the exact clock of an empty-hold frame load
    repeat (511) @(negedge clk);
    #1;
    sample_l = 16'hC3A5; sample_r = 16'h5A3C; sample_valid = 1'b1;
    chk("edge_ready", 32'(sample_ready), 32'd1);
    chk("edge_fs_before", 32'(frame_start), 32'd0);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(negedge clk); #1;
    chk("edge_fs", 32'(frame_start), 32'd1);
    chk("edge_und", 32'(underrun), 32'd1);
    chk("edge_ready_after", 32'(sample_ready), 32'd0);
    chk("edge_frame_index", 32'(fs_cnt - 1), 32'(r0 + 1));
    set_exp(r0 + 1, 16'h0000, 16'h0000, 1'b1);
    wait_fs(idx);
    set_exp(idx, 16'hC3A5, 16'h5A3C, 1'b0);
    wait_fs(idx);

    // Compare every decoded frame that has an expectation
    for (int i = 0; i < NF; i++) begin
      if (e_v[i]) begin
        chk($sformatf("frame%0d_complete", i), 32'(f_done[i]), 32'd1);
        chk($sformatf("frame%0d_left", i),     32'(f_l[i]),    32'(e_l[i]));
        chk($sformatf("frame%0d_right", i),    32'(f_r[i]),    32'(e_r[i]));
        chk($sformatf("frame%0d_underrun", i), 32'(f_und[i]),  32'(e_u[i]));
        chk($sformatf("frame%0d_pad", i),      32'(f_pad[i]),  32'd1);
        chk($sformatf("frame%0d_ws", i),       32'(f_ws[i]),   32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
